// File: rtl/brick_pkg.sv
// Shared geometry constants, colour type and helpers for the brick field.
// Imported by the decoder and the brick_wall top.
package brick_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [23:0] color_t;

  // Row 0 sits in the LSBs; rows 4..7 only matter when ROWS is raised.
  localparam logic [8*24-1:0] DEFAULT_ROW_COLORS = {
    24'hFFFFFF, 24'h00FFFF, 24'h8000FF, 24'h0000FF,
    24'h00FF00, 24'hFFFF00, 24'hFF8000, 24'hFF0000
  };

  // Index width for an n-entry brick bitmap (at least one bit).
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // 11-bit bound clamped to the screen edge so off-screen bricks shrink instead of wrapping.
  function automatic logic [10:0] clip11(input int v, input int lim);
    return (v > lim) ? 11'(lim) : 11'(v);
  endfunction
endpackage

// File: rtl/brick_decode.sv
// Combinational (x,y) -> {in_brick,row,col} via parallel compares against elaborated bounds.
// Zero latency, no flow control; shared by the render and hit paths so both see one geometry.
module brick_decode
  import brick_pkg::*;
#(
  parameter int COLS    = 5,
  parameter int ROWS    = 4,
  parameter int BRICK_W = 124,
  parameter int BRICK_H = 20,
  parameter int GAP     = 4,
  parameter int TOP     = 4
) (
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  output logic       o_in_brick,
  output logic [2:0] o_row,
  output logic [2:0] o_col
);
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic        w_col_hit;
  logic        w_row_hit;

  assign w_x = {1'b0, i_x};
  assign w_y = {1'b0, i_y};

  always_comb begin
    w_col_hit = 1'b0;
    o_col     = '0;
    for (int c = 0; c < COLS; c++) begin
      if (w_x >= clip11(c * (BRICK_W + GAP), SCREEN_W) &&
          w_x <  clip11(c * (BRICK_W + GAP) + BRICK_W, SCREEN_W)) begin
        w_col_hit = 1'b1;
        o_col     = 3'(c);
      end
    end
  end

  always_comb begin
    w_row_hit = 1'b0;
    o_row     = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (w_y >= clip11(TOP + r * (BRICK_H + GAP), SCREEN_H) &&
          w_y <  clip11(TOP + r * (BRICK_H + GAP) + BRICK_H, SCREEN_H)) begin
        w_row_hit = 1'b1;
        o_row     = 3'(r);
      end
    end
  end

  assign o_in_brick = w_col_hit & w_row_hit;
endmodule

// File: rtl/brick_wall.sv
// ROWS x COLS brick renderer and hit tracker: 1-cycle registered colour and hit response.
// No backpressure: a query is accepted every cycle it is presented; level_load beats a hit.
module brick_wall
  import brick_pkg::*;
#(
  parameter int              COLS       = 5,
  parameter int              ROWS       = 4,
  parameter int              BRICK_W    = 124,
  parameter int              BRICK_H    = 20,
  parameter int              GAP        = 4,
  parameter int              TOP        = 4,
  parameter logic [8*24-1:0] ROW_COLORS = DEFAULT_ROW_COLORS
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_active_pixels,
  output color_t     o_vga_color,
  input  logic       i_hit_valid,
  input  logic [9:0] i_hit_x,
  input  logic [9:0] i_hit_y,
  output logic       o_hit_done,
  output logic       o_hit_brick,
  output logic [2:0] o_hit_row,
  output logic [2:0] o_hit_col,
  input  logic       i_level_load,
  output logic [6:0] o_bricks_left,
  output logic       o_wall_clear
);
  localparam int NB    = ROWS * COLS;
  localparam int IDX_W = idx_w(NB);
  localparam int AW    = 2 ** IDX_W;
  localparam logic [AW-1:0] ALL_ALIVE = AW'({NB{1'b1}});

  logic [AW-1:0]    r_alive;
  logic [6:0]       r_bricks_left;
  color_t           r_vga_color;
  logic             r_hit_done;
  logic             r_hit_brick;
  logic [2:0]       r_hit_row;
  logic [2:0]       r_hit_col;

  logic             w_pix_in;
  logic [2:0]       w_pix_row;
  logic [2:0]       w_pix_col;
  logic [IDX_W-1:0] w_pix_idx;
  color_t           w_row_color;
  logic             w_hit_in;
  logic [2:0]       w_hit_row;
  logic [2:0]       w_hit_col;
  logic [IDX_W-1:0] w_hit_idx;

  brick_decode #(
    .COLS(COLS), .ROWS(ROWS), .BRICK_W(BRICK_W),
    .BRICK_H(BRICK_H), .GAP(GAP), .TOP(TOP)
  ) u_pix_decode (
    .i_x       (i_x),
    .i_y       (i_y),
    .o_in_brick(w_pix_in),
    .o_row     (w_pix_row),
    .o_col     (w_pix_col)
  );

  brick_decode #(
    .COLS(COLS), .ROWS(ROWS), .BRICK_W(BRICK_W),
    .BRICK_H(BRICK_H), .GAP(GAP), .TOP(TOP)
  ) u_hit_decode (
    .i_x       (i_hit_x),
    .i_y       (i_hit_y),
    .o_in_brick(w_hit_in),
    .o_row     (w_hit_row),
    .o_col     (w_hit_col)
  );

  assign w_pix_idx = IDX_W'(int'(w_pix_row) * COLS + int'(w_pix_col));
  assign w_hit_idx = IDX_W'(int'(w_hit_row) * COLS + int'(w_hit_col));

  always_comb begin
    w_row_color = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (w_pix_row == 3'(r)) w_row_color = ROW_COLORS[r*24 +: 24];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_alive       <= ALL_ALIVE;
      r_bricks_left <= 7'(NB);
      r_vga_color   <= '0;
      r_hit_done    <= 1'b0;
      r_hit_brick   <= 1'b0;
      r_hit_row     <= '0;
      r_hit_col     <= '0;
    end else begin
      r_vga_color <= (i_active_pixels && w_pix_in && r_alive[w_pix_idx]) ? w_row_color : '0;
      r_hit_done  <= i_hit_valid;
      r_hit_brick <= 1'b0;
      r_hit_row   <= '0;
      r_hit_col   <= '0;
      if (i_level_load) begin
        r_alive       <= ALL_ALIVE;
        r_bricks_left <= 7'(NB);
      end else if (i_hit_valid && w_hit_in && r_alive[w_hit_idx]) begin
        // Only live bricks decrement, so the count cannot underflow.
        r_alive[w_hit_idx] <= 1'b0;
        r_bricks_left      <= r_bricks_left - 7'd1;
        r_hit_brick        <= 1'b1;
        r_hit_row          <= w_hit_row;
        r_hit_col          <= w_hit_col;
      end
    end
  end

  assign o_vga_color   = r_vga_color;
  assign o_hit_done    = r_hit_done;
  assign o_hit_brick   = r_hit_brick;
  assign o_hit_row     = r_hit_row;
  assign o_hit_col     = r_hit_col;
  assign o_bricks_left = r_bricks_left;
  assign o_wall_clear  = (r_bricks_left == 7'd0);
endmodule

// File: tb/tb_brick_wall.sv
// Directed bench for brick_wall with default geometry (5x4 bricks, 124x20, gap 4, top 4).
// Inputs change #1 after a rising edge; outputs are read at that same point, after the edge that produced them.
module tb_brick_wall;
  logic        clk;
  logic        rst_n;
  logic [9:0]  x, y, hit_x, hit_y;
  logic        active_pixels, hit_valid, level_load;
  logic [23:0] vga_color;
  logic        hit_done, hit_brick, wall_clear;
  logic [2:0]  hit_row, hit_col;
  logic [6:0]  bricks_left;

  int n_checks = 0;
  int n_pass   = 0;

  brick_wall dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_x            (x),
    .i_y            (y),
    .i_active_pixels(active_pixels),
    .o_vga_color    (vga_color),
    .i_hit_valid    (hit_valid),
    .i_hit_x        (hit_x),
    .i_hit_y        (hit_y),
    .o_hit_done     (hit_done),
    .o_hit_brick    (hit_brick),
    .o_hit_row      (hit_row),
    .o_hit_col      (hit_col),
    .i_level_load   (level_load),
    .o_bricks_left  (bricks_left),
    .o_wall_clear   (wall_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int px, input int py, input logic act);
    x = 10'(px);
    y = 10'(py);
    active_pixels = act;
  endtask

  task automatic query(input int qx, input int qy);
    hit_valid = 1'b1;
    hit_x = 10'(qx);
    hit_y = 10'(qy);
  endtask

  initial begin
    rst_n = 1'b0; x = '0; y = '0; active_pixels = 1'b0;
    hit_valid = 1'b0; hit_x = '0; hit_y = '0; level_load = 1'b0;
    step(); step();
    check("rst_vga", 32'(vga_color), 32'h0);
    check("rst_done", 32'(hit_done), 32'h0);
    check("rst_brick", 32'(hit_brick), 32'h0);
    check("rst_left", 32'(bricks_left), 32'd20);
    check("rst_clear", 32'(wall_clear), 32'h0);
    rst_n = 1'b1;

    // Rendering: row colours, gap column, right edge past the last column.
    pixel(0, 4, 1'b1); step();
    check("pix_0_4", 32'(vga_color), 32'hFF0000);
    pixel(124, 4, 1'b1); step();
    check("pix_gap", 32'(vga_color), 32'h0);
    pixel(600, 80, 1'b1); step();
    check("pix_r3c4", 32'(vga_color), 32'h00FF00);
    pixel(639, 80, 1'b1); step();
    check("pix_right_edge", 32'(vga_color), 32'h0);
    pixel(123, 23, 1'b1); step();
    check("pix_last_corner", 32'(vga_color), 32'hFF0000);

    // Hit row1 col1; render of the same pixel still sees the old alive bit on this edge.
    pixel(130, 30, 1'b1); query(130, 30); step();
    check("hit1_done", 32'(hit_done), 32'h1);
    check("hit1_brick", 32'(hit_brick), 32'h1);
    check("hit1_row", 32'(hit_row), 32'd1);
    check("hit1_col", 32'(hit_col), 32'd1);
    check("hit1_left", 32'(bricks_left), 32'd19);
    check("hit1_pix_old", 32'(vga_color), 32'hFF8000);
    step();
    check("rehit_done", 32'(hit_done), 32'h1);
    check("rehit_brick", 32'(hit_brick), 32'h0);
    check("rehit_left", 32'(bricks_left), 32'd19);
    check("dead_pix", 32'(vga_color), 32'h0);
    query(126, 10); step();
    check("gap_done", 32'(hit_done), 32'h1);
    check("gap_brick", 32'(hit_brick), 32'h0);
    hit_valid = 1'b0; step();
    check("done_pulse", 32'(hit_done), 32'h0);

    // Restore, then clear the whole wall with back-to-back centre queries.
    level_load = 1'b1; step();
    level_load = 1'b0;
    check("load_left", 32'(bricks_left), 32'd20);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 5; c++) begin
        query(c * 128 + 62, 4 + r * 24 + 10); step();
        check("b2b_brick", 32'(hit_brick), 32'h1);
        check("b2b_row", 32'(hit_row), 32'(r));
        check("b2b_col", 32'(hit_col), 32'(c));
        check("b2b_left", 32'(bricks_left), 32'(19 - (r * 5 + c)));
      end
    end
    hit_valid = 1'b0; pixel(0, 4, 1'b1); step();
    check("clear_left", 32'(bricks_left), 32'd0);
    check("clear_flag", 32'(wall_clear), 32'h1);
    check("clear_pix", 32'(vga_color), 32'h0);
    query(62, 14); step();
    check("empty_brick", 32'(hit_brick), 32'h0);
    check("empty_left", 32'(bricks_left), 32'd0);

    // Load and hit together: load wins, response still comes back.
    level_load = 1'b1; query(62, 14); step();
    level_load = 1'b0; hit_valid = 1'b0;
    check("ld_hit_done", 32'(hit_done), 32'h1);
    check("ld_hit_brick", 32'(hit_brick), 32'h0);
    check("ld_hit_left", 32'(bricks_left), 32'd20);
    check("ld_hit_clear", 32'(wall_clear), 32'h0);
    pixel(130, 30, 1'b1); step();
    check("ld_pix_r1", 32'(vga_color), 32'hFF8000);
    pixel(62, 14, 1'b1); step();
    check("ld_pix_r0", 32'(vga_color), 32'hFF0000);
    pixel(600, 58, 1'b1); step();
    check("ld_pix_r2", 32'(vga_color), 32'hFFFF00);

    pixel(0, 4, 1'b0); step();
    check("inactive_pix", 32'(vga_color), 32'h0);

    // Reset during a pending query cancels it and restores the wall.
    query(62, 14); step();
    check("pre_rst_left", 32'(bricks_left), 32'd19);
    query(190, 14); rst_n = 1'b0; step();
    check("mid_rst_done", 32'(hit_done), 32'h0);
    check("mid_rst_left", 32'(bricks_left), 32'd20);
    rst_n = 1'b1; hit_valid = 1'b0; step();
    check("post_rst_done", 32'(hit_done), 32'h0);
    query(62, 14); step();
    hit_valid = 1'b0;
    check("post_rst_brick", 32'(hit_brick), 32'h1);
    check("post_rst_left", 32'(bricks_left), 32'd19);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
